// File: rtl/mem_pkg.sv
// Shared widths and types for the line-granular main memory model.
package mem_pkg;

    localparam int unsigned LINE_W      = 128;
    localparam int unsigned LINE_ADDR_W = 28;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } mem_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } mem_owner_t;

    // Request latched at grant time; the line index is held separately.
    typedef struct packed {
        logic              we;
        mem_owner_t        owner;
        logic [LINE_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port grant logic for main_memory: fixed D priority by default,
// round-robin between I and D when MAIN_MEMORY_RR_ARB_EN is defined.
module mem_arbiter
    import mem_pkg::*;
(
`ifdef MAIN_MEMORY_RR_ARB_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       req_ins_i,
    input  logic       req_dat_i,
    input  logic       grant_en_i,
    output logic [1:0] grant_c
);

    logic pick_d_c;

`ifdef MAIN_MEMORY_RR_ARB_EN
    logic last_d_q, last_d_d;

    // The owner granted last loses a tie; reset favours D.
    always_comb begin
        pick_d_c = req_dat_i && (!req_ins_i || !last_d_q);
        last_d_d = last_d_q;
        if (grant_en_i && (req_ins_i || req_dat_i)) begin
            last_d_d = pick_d_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign pick_d_c = req_dat_i;
`endif

    always_comb begin
        grant_c = '0;
        if (grant_en_i) begin
            grant_c[OWN_D] = pick_d_c;
            grant_c[OWN_I] = req_ins_i && !pick_d_c;
        end
    end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency line memory serving I-cache fills and D-cache reads/writes,
// one request at a time. MAIN_MEMORY_RR_ARB_EN selects round-robin arbitration.
module main_memory
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY   = 5,
    parameter int unsigned MEM_LINES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reqI_mem,
    input  logic [LINE_ADDR_W-1:0] reqAddrI_mem,
    input  logic                   reqD_mem,
    input  logic                   reqD_we,
    input  logic [LINE_ADDR_W-1:0] reqAddrD_mem,
    input  logic [LINE_W-1:0]      data_to_mem,
    output logic                   readyI,
    output logic [LINE_W-1:0]      dataI,
    output logic                   readyD,
    output logic [LINE_W-1:0]      dataD,
    output logic                   written_data_ack,
    output logic                   busy
);

    localparam int unsigned IDX_W = $clog2(MEM_LINES);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    mem_req_t          req_q, req_d;
    logic              ready_i_q, ready_i_d;
    logic              ready_d_q, ready_d_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [LINE_W-1:0] data_i_q, data_i_d;
    logic [LINE_W-1:0] data_d_q, data_d_d;
    logic [LINE_W-1:0] mem_q [MEM_LINES];
    logic [1:0]        grant_c;
    logic              grant_en_c;
    logic              commit_c;
    logic              unused_addr_c;

    // Upper line-address bits alias onto the array.
    assign unused_addr_c = ^{reqAddrI_mem[LINE_ADDR_W-1:IDX_W], reqAddrD_mem[LINE_ADDR_W-1:IDX_W]};
    assign grant_en_c    = (state_q == IDLE);

    mem_arbiter u_arb (
`ifdef MAIN_MEMORY_RR_ARB_EN
        .clk        (clk),
        .rst_n      (reset),
`endif
        .req_ins_i  (reqI_mem),
        .req_dat_i  (reqD_mem),
        .grant_en_i (grant_en_c),
        .grant_c    (grant_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        req_d     = req_q;
        ready_i_d = 1'b0;
        ready_d_d = 1'b0;
        ack_d     = 1'b0;
        data_i_d  = data_i_q;
        data_d_d  = data_d_q;
        commit_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|grant_c) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (grant_c[OWN_D]) begin
                        idx_d = reqAddrD_mem[IDX_W-1:0];
                        req_d = '{we: reqD_we, owner: OWN_D, data: data_to_mem};
                    end else begin
                        idx_d = reqAddrI_mem[IDX_W-1:0];
                        req_d = '{we: 1'b0, owner: OWN_I, data: req_q.data};
                    end
                end
            end
            WAIT: begin
                // Response registers load on the edge that enters RESPOND.
                if (cnt_q == '0) begin
                    state_d = RESPOND;
                    if (req_q.we) begin
                        ack_d    = 1'b1;
                        commit_c = 1'b1;
                    end else if (req_q.owner == OWN_D) begin
                        ready_d_d = 1'b1;
                        data_d_d  = mem_q[idx_q];
                    end else begin
                        ready_i_d = 1'b1;
                        data_i_d  = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            req_q     <= '0;
            ready_i_q <= 1'b0;
            ready_d_q <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            data_i_q  <= '0;
            data_d_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            req_q     <= req_d;
            ready_i_q <= ready_i_d;
            ready_d_q <= ready_d_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            data_i_q  <= data_i_d;
            data_d_q  <= data_d_d;
        end
    end

    // Array is never cleared; an aborted write never reaches it.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem_q[idx_q] <= req_q.data;
        end
    end

    assign readyI           = ready_i_q;
    assign dataI            = data_i_q;
    assign readyD           = ready_d_q;
    assign dataD            = data_d_q;
    assign written_data_ack = ack_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: vector table with a response scoreboard,
// plus hand sequences for latency, arbitration, LATENCY=1 and reset abort.
module tb_main_memory;
    import mem_pkg::*;

    localparam int unsigned LAT   = 5;
    localparam logic [1:0]  K_I   = 2'd0;
    localparam logic [1:0]  K_D   = 2'd1;
    localparam logic [1:0]  K_ACK = 2'd2;

    localparam logic [127:0] A  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] B  = 128'hA5A5_5A5A_0F0F_F0F0_1357_9BDF_2468_ACE0;
    localparam logic [127:0] C  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] DB = {4{32'hDEAD_BEEF}};
    localparam logic [127:0] D2 = 128'hCAFE_F00D_0BAD_C0DE_FACE_B00C_8BAD_F00D;
    localparam logic [127:0] X  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         reqI_mem, reqD_mem, reqD_we;
    logic [27:0]  reqAddrI_mem, reqAddrD_mem;
    logic [127:0] data_to_mem;
    logic         readyI, readyD, written_data_ack, busy;
    logic [127:0] dataI, dataD;
    logic         readyI_1, readyD_1, ack_1, busy_1;
    logic [127:0] dataI_1, dataD_1;

    always #5 clk = ~clk;

    main_memory #(.LATENCY(LAT), .MEM_LINES(4096)) u_dut (
        .clk(clk), .reset(rst_n),
        .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .reqD_mem(reqD_mem), .reqD_we(reqD_we), .reqAddrD_mem(reqAddrD_mem),
        .data_to_mem(data_to_mem),
        .readyI(readyI), .dataI(dataI), .readyD(readyD), .dataD(dataD),
        .written_data_ack(written_data_ack), .busy(busy)
    );

    main_memory #(.LATENCY(1), .MEM_LINES(16)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .reqD_mem(reqD_mem), .reqD_we(reqD_we), .reqAddrD_mem(reqAddrD_mem),
        .data_to_mem(data_to_mem),
        .readyI(readyI_1), .dataI(dataI_1), .readyD(readyD_1), .dataD(dataD_1),
        .written_data_ack(ack_1), .busy(busy_1)
    );

    typedef struct {
        logic [1:0]   kind;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        logic         is_d;
        logic         we;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    logic [1:0]   mon_k;
    logic [127:0] mon_d;
    exp_t         mon_e;

    function automatic void push_exp(input logic [1:0] kind, input logic [127:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor on the LATENCY=5 instance.
    always @(negedge clk) begin
        if (readyI || readyD || written_data_ack) begin
            tests++;
            mon_k = readyI ? K_I : (readyD ? K_D : K_ACK);
            mon_d = readyI ? dataI : dataD;
            if ((int'(readyI) + int'(readyD) + int'(written_data_ack)) != 1) begin
                fails++;
                $display("FAIL resp_onehot: got I=%0b D=%0b ack=%0b expected one pulse",
                         readyI, readyD, written_data_ack);
            end else if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL resp_unexpected: got kind %0d expected no response", mon_k);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_k != mon_e.kind || (mon_k != K_ACK && mon_d !== mon_e.data)) begin
                    fails++;
                    $display("FAIL resp_sb: got kind %0d data %h expected kind %0d data %h",
                             mon_k, mon_d, mon_e.kind, mon_e.data);
                end
            end
        end
    end

    task automatic do_req(input vec_t v);
        bit got;
        @(negedge clk);
        if (v.is_d) begin
            reqD_mem = 1'b1; reqD_we = v.we; reqAddrD_mem = v.addr; data_to_mem = v.wdata;
        end else begin
            reqI_mem = 1'b1; reqAddrI_mem = v.addr;
        end
        push_exp(v.is_d ? (v.we ? K_ACK : K_D) : K_I, v.exp);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (readyI || readyD || written_data_ack) got = 1'b1;
        end
        reqI_mem = 1'b0; reqD_mem = 1'b0; reqD_we = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL req_timeout: got no response for addr %h expected one", v.addr);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    vec_t vecs[12];
    int   pulse_at, busy_n, pulse_n, n_arb, p1, p2;
    logic [127:0] d1_cap;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 28'h0000004, A,  '0};
        vecs[1]  = '{1'b1, 1'b1, 28'h0000005, B,  '0};
        vecs[2]  = '{1'b1, 1'b1, 28'h0000010, C,  '0};
        vecs[3]  = '{1'b1, 1'b0, 28'h0000004, '0, A};
        vecs[4]  = '{1'b0, 1'b0, 28'h0000005, '0, B};
        vecs[5]  = '{1'b1, 1'b1, 28'h0000020, DB, '0};
        vecs[6]  = '{1'b0, 1'b0, 28'h0000020, '0, DB};
        vecs[7]  = '{1'b1, 1'b0, 28'h0001005, '0, B};
        vecs[8]  = '{1'b0, 1'b0, 28'hFFFF004, '0, A};
        vecs[9]  = '{1'b1, 1'b1, 28'h0000004, D2, '0};
        vecs[10] = '{1'b1, 1'b0, 28'h0000004, '0, D2};
        vecs[11] = '{1'b0, 1'b0, 28'h0000010, '0, C};

        rst_n = 1'b0; reqI_mem = 1'b0; reqD_mem = 1'b0; reqD_we = 1'b0;
        reqAddrI_mem = '0; reqAddrD_mem = '0; data_to_mem = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   128'(busy), 128'(0));
        check("rst_readyI", 128'(readyI), 128'(0));
        check("rst_readyD", 128'(readyD), 128'(0));
        check("rst_ack",    128'(written_data_ack), 128'(0));
        check("rst_dataI",  dataI, '0);
        check("rst_dataD",  dataD, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) do_req(vecs[i]);
        check("data_hold", dataI, C);

        // LATENCY=5 timing of an I read.
        @(negedge clk);
        reqI_mem = 1'b1; reqAddrI_mem = 28'h5;
        push_exp(K_I, B);
        pulse_at = 0; busy_n = 0; pulse_n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (readyI) begin
                pulse_n++;
                if (pulse_at == 0) pulse_at = k;
                reqI_mem = 1'b0;
            end
        end
        check("lat_pulse_at", 128'(pulse_at), 128'(LAT + 1));
        check("lat_busy_span", 128'(busy_n), 128'(LAT + 1));
        check("lat_pulse_cnt", 128'(pulse_n), 128'(1));

        // Both ports held: four grants.
`ifdef MAIN_MEMORY_RR_ARB_EN
        push_exp(K_D, B); push_exp(K_I, D2); push_exp(K_D, B); push_exp(K_I, D2);
`else
        push_exp(K_D, B); push_exp(K_D, B); push_exp(K_D, B); push_exp(K_D, B);
`endif
        @(negedge clk);
        reqI_mem = 1'b1; reqAddrI_mem = 28'h4;
        reqD_mem = 1'b1; reqD_we = 1'b0; reqAddrD_mem = 28'h5;
        n_arb = 0;
        for (int k = 0; k < 100 && n_arb < 4; k++) begin
            @(negedge clk);
            if (readyI || readyD) n_arb++;
        end
        reqI_mem = 1'b0; reqD_mem = 1'b0;
        check("arb_count", 128'(n_arb), 128'(4));
        repeat (LAT + 4) @(negedge clk);
        check("arb_drained", 128'(sb_q.size()), 128'(0));

        // LATENCY=1 instance: held I request, pulse spacing.
        @(negedge clk);
        reqI_mem = 1'b1; reqAddrI_mem = 28'h4;
        push_exp(K_I, D2);
        p1 = 0; p2 = 0; d1_cap = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (readyI_1) begin
                if (p1 == 0) begin p1 = k; d1_cap = dataI_1; end
                else if (p2 == 0) p2 = k;
            end
        end
        reqI_mem = 1'b0;
        check("lat1_first", 128'(p1), 128'(2));
        check("lat1_second", 128'(p2), 128'(5));
        check("lat1_data", d1_cap, D2);
        repeat (LAT + 3) @(negedge clk);

        // Reset in WAIT of a write to 0x10 aborts it.
        @(negedge clk);
        reqD_mem = 1'b1; reqD_we = 1'b1; reqAddrD_mem = 28'h10; data_to_mem = X;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_pre", 128'(busy), 128'(1));
        rst_n = 1'b0; reqD_mem = 1'b0; reqD_we = 1'b0;
        #2;
        check("abort_busy_rst", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        do_req('{1'b1, 1'b0, 28'h0000010, '0, C});

        repeat (4) @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
